// File: rtl/fpu_unpack.sv
// Operand front end of the FPU: splits an IEEE single into sign, prenorm exponent
// and explicit-hidden-bit mantissa, classifies it and left-normalizes denormals.
module fpu_unpack #(
    parameter int unsigned C_SHIFT_STEP  = 4,
    parameter int unsigned C_EXP_PRENORM = 10
) (
    input  logic                     Clk_CI,
    input  logic                     Rst_RBI,
    input  logic                     Flush_SI,
    input  logic [31:0]              Operand_DI,
    input  logic                     In_valid_SI,
    output logic                     In_ready_SO,
    output logic                     Sign_DO,
    output logic [C_EXP_PRENORM-1:0] Exp_DO,
    output logic [23:0]              Mant_DO,
    output logic                     Zero_SO,
    output logic                     Inf_SO,
    output logic                     NaN_SO,
    output logic                     SNaN_SO,
    output logic                     Denormal_SO,
    output logic                     Out_valid_SO,
    input  logic                     Out_ready_SI
);

    localparam int unsigned C_MANT = 23;
    localparam int unsigned C_EXP  = 8;
    localparam int unsigned C_LZ_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        DONE
    } state_t;

    typedef struct packed {
        logic                     sign;
        logic [C_EXP_PRENORM-1:0] exp;
        logic [C_MANT:0]          mant;
        logic                     zero;
        logic                     inf;
        logic                     nan;
        logic                     snan;
        logic                     denormal;
    } op_t;

    state_t state_q, state_d;
    op_t    op_q, op_d;
    op_t    dec;
    logic   valid_q;

    logic [C_EXP-1:0]  exp_f;
    logic [C_MANT-1:0] frac_f;
    logic [C_LZ_W-1:0] lz;
    logic              found;
    logic              accept;

    assign exp_f  = Operand_DI[30:23];
    assign frac_f = Operand_DI[22:0];

    // Field decode and classification of the incoming word
    always_comb begin
        dec      = '0;
        dec.sign = Operand_DI[31];
        if (exp_f == '0) begin
            if (frac_f == '0) begin
                dec.zero = 1'b1;
            end else begin
                dec.exp      = C_EXP_PRENORM'(1);
                dec.mant     = {1'b0, frac_f};
                dec.denormal = 1'b1;
            end
        end else if (exp_f == '1) begin
            dec.exp = C_EXP_PRENORM'(exp_f);
            if (frac_f == '0) begin
                dec.mant = {1'b1, {C_MANT{1'b0}}};
                dec.inf  = 1'b1;
            end else begin
                dec.mant = {1'b1, frac_f};
                dec.nan  = 1'b1;
                dec.snan = ~frac_f[C_MANT-1];
            end
        end else begin
            dec.exp  = C_EXP_PRENORM'(exp_f);
            dec.mant = {1'b1, frac_f};
        end
    end

    // Leading-zero count inside the top C_SHIFT_STEP mantissa bits
    always_comb begin
        lz    = '0;
        found = 1'b0;
        for (int i = 0; i < int'(C_SHIFT_STEP); i++) begin
            if (!found) begin
                if (op_q.mant[int'(C_MANT) - i]) begin
                    found = 1'b1;
                end else begin
                    lz = lz + C_LZ_W'(1);
                end
            end
        end
    end

    // Ready never looks at In_valid_SI; in DONE it follows the consumer
    assign In_ready_SO = (state_q == IDLE) || ((state_q == DONE) && Out_ready_SI);
    assign accept      = In_valid_SI && In_ready_SO && !Flush_SI;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        if (Flush_SI) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                NORM: begin
                    if (!found) begin
                        op_d.mant = op_q.mant << C_SHIFT_STEP;
                        op_d.exp  = op_q.exp - C_EXP_PRENORM'(C_SHIFT_STEP);
                    end else begin
                        op_d.mant = op_q.mant << lz;
                        op_d.exp  = op_q.exp - C_EXP_PRENORM'(lz);
                        state_d   = DONE;
                    end
                end
                DONE: begin
                    if (Out_ready_SI) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
            if (accept) begin
                op_d    = dec;
                state_d = dec.denormal ? NORM : DONE;
            end
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            state_q <= IDLE;
            op_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            valid_q <= (state_d == DONE);
        end
    end

    assign Sign_DO      = op_q.sign;
    assign Exp_DO       = op_q.exp;
    assign Mant_DO      = op_q.mant;
    assign Zero_SO      = op_q.zero;
    assign Inf_SO       = op_q.inf;
    assign NaN_SO       = op_q.nan;
    assign SNaN_SO      = op_q.snan;
    assign Denormal_SO  = op_q.denormal;
    assign Out_valid_SO = valid_q;

endmodule

// File: tb/tb_fpu_unpack.sv
// Scoreboard bench for fpu_unpack: directed operands, expected fields queued at accept.
`timescale 1ns/1ps
module tb_fpu_unpack;

    localparam int unsigned STEP = 4;
    localparam int unsigned EW   = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [31:0]   operand = '0;
    logic          in_ready, out_valid;
    logic          sign, zero, inf, nan, snan, den;
    logic [EW-1:0] exp_o;
    logic [23:0]   mant;

    typedef struct {
        logic [39:0] val;
        int          lat;
        int          t0;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [39:0] held = '0;
    logic        pend = 1'b0;
    wire  [39:0] outs = {sign, exp_o, mant, zero, inf, nan, snan, den};

    fpu_unpack #(.C_SHIFT_STEP(STEP), .C_EXP_PRENORM(EW)) dut (
        .Clk_CI      (clk),
        .Rst_RBI     (rst_n),
        .Flush_SI    (flush),
        .Operand_DI  (operand),
        .In_valid_SI (in_valid),
        .In_ready_SO (in_ready),
        .Sign_DO     (sign),
        .Exp_DO      (exp_o),
        .Mant_DO     (mant),
        .Zero_SO     (zero),
        .Inf_SO      (inf),
        .NaN_SO      (nan),
        .SNaN_SO     (snan),
        .Denormal_SO (den),
        .Out_valid_SO(out_valid),
        .Out_ready_SI(out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // {sign, exp, mant, zero, inf, nan, snan, denormal}
    function automatic logic [39:0] mk(input logic s, input logic [9:0] e,
                                       input logic [23:0] m, input logic [4:0] f);
        return {s, e, m, f};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: latency on first sight, stability while stalled, fields on transfer
    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            if (!pend) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_result: got %0h expected none", outs);
                end else begin
                    check("latency", 64'(cyc - sb[0].t0), 64'(sb[0].lat));
                end
                held = outs;
            end else begin
                check("hold_stable", 64'(outs), 64'(held));
            end
            if (out_ready) begin
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("result", 64'(outs), 64'(e.val));
                end
                pend = 1'b0;
            end else begin
                pend = 1'b1;
            end
        end else begin
            pend = 1'b0;
        end
    end

    task automatic send(input logic [31:0] op, input logic [39:0] val, input int lat);
        exp_t e;
        int   n = 0;
        operand  = op;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end else begin
            e.val = val;
            e.lat = lat;
            e.t0  = cyc;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_queue_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int cnt;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_outputs", 64'(outs), 64'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Normals
        send(32'h3F80_0000, mk(1'b0, 10'd127, 24'h80_0000, 5'b00000), 1);
        drain();
        send(32'hC000_0000, mk(1'b1, 10'd128, 24'h80_0000, 5'b00000), 1);
        drain();

        // Smallest denormal: six NORM cycles with ready low
        send(32'h0000_0001, mk(1'b0, 10'h3EA, 24'h80_0000, 5'b00001), 7);
        cnt = 0;
        while (!in_ready && cnt < 50) begin
            cnt++;
            @(posedge clk); #1;
        end
        check("norm_busy_cycles", 64'(cnt), 64'd6);
        drain();
        send(32'h0040_0000, mk(1'b0, 10'h000, 24'h80_0000, 5'b00001), 2);
        drain();
        send(32'h0000_0010, mk(1'b0, 10'h3EE, 24'h80_0000, 5'b00001), 6);
        drain();

        // Specials, issued back to back
        send(32'h7F80_0000, mk(1'b0, 10'd255, 24'h80_0000, 5'b01000), 1);
        send(32'h7FA0_0000, mk(1'b0, 10'd255, 24'hA0_0000, 5'b00110), 1);
        send(32'h7FC0_0000, mk(1'b0, 10'd255, 24'hC0_0000, 5'b00100), 1);
        send(32'h8000_0000, mk(1'b1, 10'd0,   24'h00_0000, 5'b10000), 1);
        drain();

        // Backpressure, then release together with a new accept
        out_ready = 1'b0;
        send(32'h4049_0FDB, mk(1'b0, 10'd128, 24'hC9_0FDB, 5'b00000), 1);
        repeat (5) begin
            check("bp_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(32'h3F80_0000, mk(1'b0, 10'd127, 24'h80_0000, 5'b00000), 1);
        drain();

        // Reset during the third NORM cycle
        send(32'h0000_0001, mk(1'b0, 10'h3EA, 24'h80_0000, 5'b00001), 7);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        void'(sb.pop_back());
        check("midnorm_reset_in_ready", 64'(in_ready), 64'd1);
        check("midnorm_reset_out_valid", 64'(out_valid), 64'd0);
        check("midnorm_reset_outputs", 64'(outs), 64'd0);
        repeat (10) @(posedge clk);
        #1;
        check("post_reset_no_valid", 64'(out_valid), 64'd0);

        // Flush in DONE drops the result
        out_ready = 1'b0;
        send(32'h3F80_0000, mk(1'b0, 10'd127, 24'h80_0000, 5'b00000), 1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        void'(sb.pop_back());
        check("flush_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("flush_no_result", 64'(out_valid), 64'd0);

        // Flush blocks an accept in the same cycle
        operand  = 32'h3F80_0000;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_blocks_accept", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("flush_blocks_accept_late", 64'(out_valid), 64'd0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
